multi_lane_xor_cipher: RTL and testbench

MULTI_LANE_XOR_CIPHER -- requirements
Module: multi_lane_xor_cipher

---
 rtl/xorc_pkg.sv | 27 ++
 rtl/xorc_lfsr_lane.sv | 49 ++++
 rtl/multi_lane_xor_cipher.sv | 137 +++++++++++++
 tb/tb_multi_lane_xor_cipher.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xorc_pkg.sv
// Shared types and chain-layout helpers for the multi-lane XOR stream cipher.
// Purely declarative: no logic, no latency, no flow control.
// Chain layout per lane, MSB down: tx_taps, tx_seed, rx_taps, rx_seed (M bits each).
package xorc_pkg;

    typedef logic [1:0] xorc_state_t;

    localparam xorc_state_t ST_IDLE = 2'd0;
    localparam xorc_state_t ST_LOAD = 2'd1;
    localparam xorc_state_t ST_RUN  = 2'd2;

    localparam int FLD_TX_TAPS   = 0;
    localparam int FLD_TX_SEED   = 1;
    localparam int FLD_RX_TAPS   = 2;
    localparam int FLD_RX_SEED   = 3;
    localparam int FLDS_PER_LANE = 4;

    function automatic int chain_len(input int m, input int lanes);
        return FLDS_PER_LANE * m * lanes;
    endfunction

    // Lane 0 occupies the top of the chain, so the first serial bit lands in lane0 tx_taps MSB.
    function automatic int field_lsb(input int m, input int lanes, input int lane, input int fld);
        return chain_len(m, lanes) - (lane * FLDS_PER_LANE + fld + 1) * m;
    endfunction

endpackage

// File: rtl/xorc_lfsr_lane.sv
// One Fibonacci LFSR keystream generator with XOR and registered output bit.
// Latency: 1 cycle din -> dout; generator steps only on enabled RUN cycles.
// No backpressure: en is a pure advance strobe; output holds when en is low.
module xorc_lfsr_lane #(
    parameter int M = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic         load,
    input  logic [M-1:0] taps_in,
    input  logic [M-1:0] seed_in,
    input  logic         en,
    input  logic         din,
    output logic         dout
);

    logic [M-1:0] taps;
    logic [M-1:0] state;
    logic         fb;
    logic         ks;

    assign ks = state[M-1];
    assign fb = ^(state & taps);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps  <= '0;
            state <= '0;
        end else if (load) begin
            taps  <= taps_in;
            // An all-zero seed would lock the generator at zero forever.
            state <= (seed_in == '0) ? {{(M-1){1'b0}}, 1'b1} : seed_in;
        end else if (run && en) begin
            state <= {state[M-2:0], fb};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= 1'b0;
        end else if (!run) begin
            dout <= 1'b0;
        end else if (en) begin
            dout <= din ^ ks;
        end
    end

endmodule

// File: rtl/multi_lane_xor_cipher.sv
// Multi-lane LFSR XOR cipher with serial shadow key chain; optional heartbeat (XORC_HEARTBEAT_EN).
// Latency: 1 cycle plaintext/ciphertext in -> registered out; key commit 1 cycle after cfg_en falls.
// No backpressure: per-lane enables advance the keystream; outputs hold when disabled, 0 outside RUN.
module multi_lane_xor_cipher
    import xorc_pkg::*;
#(
    parameter int M       = 32,
    parameter int LANES   = 2,
    parameter int HB_BITS = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_en,
    input  logic             cfg_i,
    output logic             cfg_o,
    input  logic [LANES-1:0] tx_en,
    input  logic [LANES-1:0] rx_en,
    input  logic [LANES-1:0] tx_p,
    input  logic [LANES-1:0] rx_e,
    output logic [LANES-1:0] tx_e,
    output logic [LANES-1:0] rx_p,
    output logic             key_valid,
    output logic             cfg_err,
    output logic             heartbeat
);

    localparam int L  = chain_len(M, LANES);
    localparam int CW = $clog2(L + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(L);
    localparam logic [CW-1:0] CNT_SAT  = CW'(L + 1);

    if (M < 8 || M > 64 || LANES < 1 || LANES > 8 || HB_BITS < 1) begin : g_bad_param
        $error("multi_lane_xor_cipher: parameter out of range");
    end

    logic [L-1:0]  shadow;
    logic [CW-1:0] shift_cnt;
    xorc_state_t   state;
    logic          prior_run;
    logic          commit;
    logic          run;

    assign run       = (state == ST_RUN);
    assign commit    = (state == ST_LOAD) && !cfg_en && (shift_cnt == CNT_FULL);
    assign key_valid = run;
    assign cfg_o     = shadow[L-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (cfg_en) begin
            shadow <= {shadow[L-2:0], cfg_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            shift_cnt <= '0;
            prior_run <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_RUN: begin
                    if (cfg_en) begin
                        state     <= ST_LOAD;
                        prior_run <= (state == ST_RUN);
                        shift_cnt <= CW'(1);
                    end
                end
                ST_LOAD: begin
                    if (cfg_en) begin
                        if (shift_cnt != CNT_SAT) begin
                            shift_cnt <= shift_cnt + 1'b1;
                        end
                    end else if (shift_cnt == CNT_FULL) begin
                        state   <= ST_RUN;
                        cfg_err <= 1'b0;
                    end else begin
                        // Short or long load: keep whatever key was running before.
                        state   <= prior_run ? ST_RUN : ST_IDLE;
                        cfg_err <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int TX_TAPS = field_lsb(M, LANES, i, FLD_TX_TAPS);
        localparam int TX_SEED = field_lsb(M, LANES, i, FLD_TX_SEED);
        localparam int RX_TAPS = field_lsb(M, LANES, i, FLD_RX_TAPS);
        localparam int RX_SEED = field_lsb(M, LANES, i, FLD_RX_SEED);

        xorc_lfsr_lane #(.M(M)) u_tx (
            .clk     (clk),
            .rst     (rst),
            .run     (run),
            .load    (commit),
            .taps_in (shadow[TX_TAPS +: M]),
            .seed_in (shadow[TX_SEED +: M]),
            .en      (tx_en[i]),
            .din     (tx_p[i]),
            .dout    (tx_e[i])
        );

        xorc_lfsr_lane #(.M(M)) u_rx (
            .clk     (clk),
            .rst     (rst),
            .run     (run),
            .load    (commit),
            .taps_in (shadow[RX_TAPS +: M]),
            .seed_in (shadow[RX_SEED +: M]),
            .en      (rx_en[i]),
            .din     (rx_e[i]),
            .dout    (rx_p[i])
        );
    end

`ifdef XORC_HEARTBEAT_EN
    logic [HB_BITS-1:0] hb_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_cnt <= '0;
        end else begin
            hb_cnt <= hb_cnt + 1'b1;
        end
    end

    assign heartbeat = hb_cnt[HB_BITS-1];
`else
    assign heartbeat = 1'b0;
`endif

endmodule

// File: tb/tb_multi_lane_xor_cipher.sv
// Randomized bench for multi_lane_xor_cipher against a bit-level keystream model.
module tb_multi_lane_xor_cipher;

    localparam int M     = 32;
    localparam int LANES = 2;
    localparam int L     = 4 * M * LANES;
    localparam int NG    = 2 * LANES;
`ifdef XORC_HEARTBEAT_EN
    localparam int HB = 4;
`else
    localparam int HB = 24;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cfg_en = 1'b0;
    logic             cfg_i = 1'b0;
    logic             cfg_o;
    logic [LANES-1:0] tx_en = '0, rx_en = '0, tx_p = '0, rx_e = '0;
    logic [LANES-1:0] tx_e, rx_p;
    logic             key_valid, cfg_err, heartbeat;

    multi_lane_xor_cipher #(.M(M), .LANES(LANES), .HB_BITS(HB)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_en    (cfg_en),
        .cfg_i     (cfg_i),
        .cfg_o     (cfg_o),
        .tx_en     (tx_en),
        .rx_en     (rx_en),
        .tx_p      (tx_p),
        .rx_e      (rx_e),
        .tx_e      (tx_e),
        .rx_p      (rx_p),
        .key_valid (key_valid),
        .cfg_err   (cfg_err),
        .heartbeat (heartbeat)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: shadow chain as a bit vector, generators as integer states.
    logic [L-1:0]     m_sh;
    logic [M-1:0]     m_tap [NG];
    logic [M-1:0]     m_st  [NG];
    logic [M-1:0]     key_tap  [NG];
    logic [M-1:0]     key_seed [NG];
    bit               m_key, m_err;
    logic [LANES-1:0] exp_tx, exp_rx;
    logic [LANES-1:0] tp_h1, tp_h2;
    int               lb_n;
    int               cyc;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic hb_expected();
`ifdef XORC_HEARTBEAT_EN
        return ((cyc >> 3) & 1) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Output the current MSB as keystream, then shift in the parity of tapped bits.
    function automatic logic ks_next(input int g);
        logic k;
        logic fb;
        k  = m_st[g][M-1];
        fb = ($countones(m_st[g] & m_tap[g]) % 2) == 1;
        m_st[g] = (m_st[g] << 1) | {{(M-1){1'b0}}, fb};
        return k;
    endfunction

    function automatic logic [M-1:0] field(input int lane, input int f);
        return m_sh[L-1-(lane*4+f)*M -: M];
    endfunction

    function automatic logic [L-1:0] pack_key();
        logic [L-1:0] kv;
        kv = '0;
        for (int i = 0; i < LANES; i++) begin
            kv[L-1-(4*i+0)*M -: M] = key_tap[2*i];
            kv[L-1-(4*i+1)*M -: M] = key_seed[2*i];
            kv[L-1-(4*i+2)*M -: M] = key_tap[2*i+1];
            kv[L-1-(4*i+3)*M -: M] = key_seed[2*i+1];
        end
        return kv;
    endfunction

    task automatic model_reset();
        m_sh   = '0;
        m_key  = 0;
        m_err  = 0;
        exp_tx = '0;
        exp_rx = '0;
    endtask

    task automatic do_load(input int nbits, input logic [L-1:0] kv);
        logic [M-1:0] s;
        tx_en = '0;
        rx_en = '0;
        for (int j = 0; j < nbits; j++) begin
            cfg_en = 1'b1;
            cfg_i  = kv[L-1-j];
            m_sh   = {m_sh[L-2:0], kv[L-1-j]};
            @(negedge clk);
        end
        cfg_en = 1'b0;
        @(negedge clk);
        if (nbits == L) begin
            for (int i = 0; i < LANES; i++) begin
                for (int d = 0; d < 2; d++) begin
                    m_tap[2*i+d] = field(i, 2*d);
                    s = field(i, 2*d + 1);
                    m_st[2*i+d] = (s == 0) ? 1 : s;
                end
            end
            m_key = 1;
            m_err = 0;
        end else begin
            m_err = 1;
        end
        check_eq("load_key_valid", key_valid, m_key);
        check_eq("load_cfg_err", cfg_err, m_err);
        check_eq("load_cfg_o", cfg_o, m_sh[L-1]);
        check_eq("load_data_zero", {tx_e, rx_p}, 0);
        exp_tx = '0;
        exp_rx = '0;
    endtask

    // mode 0: random traffic; 1: tx->rx loopback; 2: tx_en alternating 1010...
    task automatic run_cycle(input int mode, input int k);
        logic [LANES-1:0] ten, ren, tp, re;
        check_eq("data", {tx_e, rx_p}, {exp_tx, exp_rx});
        check_eq("key_valid", key_valid, m_key);
        check_eq("heartbeat", heartbeat, hb_expected());
        tp = LANES'($urandom);
        re = LANES'($urandom);
        ten = LANES'($urandom);
        ren = LANES'($urandom);
        if (mode == 1) begin
            if (lb_n >= 2) check_eq("loopback", rx_p, tp_h2);
            ten = '1;
            ren = (lb_n == 0) ? '0 : '1;
            re  = tx_e;
            tp_h2 = tp_h1;
            tp_h1 = tp;
            lb_n++;
        end else if (mode == 2) begin
            ten = (k % 2 == 0) ? '1 : '0;
        end
        if (m_key) begin
            for (int i = 0; i < LANES; i++) begin
                if (ten[i]) exp_tx[i] = tp[i] ^ ks_next(2*i);
                if (ren[i]) exp_rx[i] = re[i] ^ ks_next(2*i+1);
            end
        end else begin
            exp_tx = '0;
            exp_rx = '0;
        end
        tx_en = ten;
        rx_en = ren;
        tx_p  = tp;
        rx_e  = re;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_data"}, {tx_e, rx_p}, 0);
        check_eq({tag, "_key_valid"}, key_valid, 0);
        check_eq({tag, "_cfg_err"}, cfg_err, 0);
        check_eq({tag, "_cfg_o"}, cfg_o, 0);
        check_eq({tag, "_heartbeat"}, heartbeat, 0);
    endtask

    initial begin
        logic [L-1:0] kv;

        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        model_reset();

        // Short load from IDLE is rejected and stays IDLE.
        kv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        do_load(20, kv);
        for (int k = 0; k < 10; k++) run_cycle(0, k);

        // Reference key, then long loopback.
        for (int g = 0; g < NG; g++) begin
            key_tap[g]  = 32'h4800_0000;
            key_seed[g] = 32'h0000_0055;
        end
        do_load(L, pack_key());
        lb_n = 0;
        tp_h1 = '0;
        tp_h2 = '0;
        for (int k = 0; k < 10000; k++) run_cycle(1, k);
        for (int k = 0; k < 300; k++) run_cycle(0, k);

        // One bit short while running: rejected, old key keeps going.
        kv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        do_load(L - 1, kv);
        for (int k = 0; k < 300; k++) run_cycle(0, k);

        // Random taps with some zero seeds.
        for (int g = 0; g < NG; g++) begin
            key_tap[g]  = M'($urandom) | {1'b1, {(M-1){1'b0}}};
            key_seed[g] = M'($urandom);
        end
        key_seed[0]      = '0;
        key_seed[NG - 1] = '0;
        do_load(L, pack_key());
        for (int k = 0; k < 200; k++) run_cycle(0, k);
        for (int k = 0; k < 200; k++) run_cycle(2, k);

        // Reset in the middle of RUN clears everything on the next edge.
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrun_reset");
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 20; k++) run_cycle(0, k);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
